// File: rtl/button_debouncer_pkg.sv
// Shared constants for pushbutton conditioning: state encodings, button
// polarity and default debounce lengths.
package button_debouncer_pkg;

    // 2-bit state encoding; bit 0 tracks "new level is low/pressed side"
    typedef enum logic [1:0] {
        REL_STABLE = 2'b00,
        PRESS_WAIT = 2'b01,
        REL_WAIT   = 2'b10,
        PRS_STABLE = 2'b11
    } db_state_t;

    // Pushbuttons are active-low on the board; the pulse FSM uses these too
    localparam logic BTN_PRESSED  = 1'b0;
    localparam logic BTN_RELEASED = 1'b1;

    // 10 ms at 50 MHz for hardware, a short window for simulation
    localparam int DEBOUNCE_CYCLES_HW  = 500000;
    localparam int DEBOUNCE_CYCLES_SIM = 4;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs (buttons, switches).
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    // Shift the async input through two flops; reset to the idle level
    always_ff @(posedge clock) begin
        if (reset) begin
            s1 <= RESET_VALUE;
            s2 <= RESET_VALUE;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/button_debouncer.sv
// Pushbutton conditioning: synchronise the raw active-low pin, require the
// new level to hold for DEBOUNCE_CYCLES+1 synchronised edges, then emit a
// clean level plus one-cycle press/release strobes.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW,
    parameter int CNT_WIDTH       = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic button_raw,
    output logic button_clean,
    output logic press_pulse,
    output logic release_pulse
);

    // Terminal count: entry edge plus DEBOUNCE_CYCLES counting edges
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 s2;
    db_state_t            state;
    logic [CNT_WIDTH-1:0] cnt;

    // Idle level of the button is released, so the synchroniser resets high
    sync_2ff #(
        .RESET_VALUE(BTN_RELEASED)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (button_raw),
        .q    (s2)
    );

    // Debounce FSM with registered level and strobes; cnt only moves in WAIT
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= REL_STABLE;
            cnt           <= '0;
            button_clean  <= BTN_RELEASED;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                REL_STABLE: begin
                    button_clean <= BTN_RELEASED;
                    cnt          <= '0;
                    if (s2 == BTN_PRESSED) begin
                        state <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (s2 == BTN_RELEASED) begin
                        state <= REL_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state        <= PRS_STABLE;
                        cnt          <= '0;
                        button_clean <= BTN_PRESSED;
                        press_pulse  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                PRS_STABLE: begin
                    button_clean <= BTN_PRESSED;
                    cnt          <= '0;
                    if (s2 == BTN_RELEASED) begin
                        state <= REL_WAIT;
                    end
                end
                REL_WAIT: begin
                    if (s2 == BTN_PRESSED) begin
                        state <= PRS_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state         <= REL_STABLE;
                        cnt           <= '0;
                        button_clean  <= BTN_RELEASED;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state        <= REL_STABLE;
                    cnt          <= '0;
                    button_clean <= BTN_RELEASED;
                end
            endcase
        end
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Upstream conditioning stage for every board pushbutton.
- Synchronises the raw, asynchronous, active-low pushbutton into the clock domain and rejects contact bounce.
- Emits a clean active-low level that drives the button_in input of the press/release pulse FSM directly.
- Also emits one-cycle press and release strobes for consumers that want edges without a second FSM.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive synchronised cycles a new level must hold before acceptance (10 ms at 50 MHz). Legal range 1 to 2^CNT_WIDTH.
- CNT_WIDTH, 20: stability counter width. Must hold DEBOUNCE_CYCLES-1.

Ports:
- clock  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- button_raw  input  1  raw pushbutton pin, asynchronous, 0 = pressed.
- button_clean  output  1  debounced level, 0 = pressed; registered.
- press_pulse  output  1  high one cycle when button_clean falls; registered.
- release_pulse  output  1  high one cycle when button_clean rises; registered.

Behaviour:
- One clock; reset is synchronous and active-high; all flops update only on posedge clock.
- Reset values:
  - both synchroniser flops = 1
  - state = REL_STABLE
  - cnt = 0
  - button_clean = 1
  - press_pulse = 0, release_pulse = 0
  - Reset wins over every other condition on the same edge.
- Synchroniser: s1 <= button_raw; s2 <= s1. The FSM sees only s2. Never use button_raw or s1 elsewhere.
- FSM, 2-bit encoding:
  - REL_STABLE (00): clean=1. If s2==0, go to PRESS_WAIT with cnt<=0. Otherwise stay.
  - PRESS_WAIT (01):
    - If s2==1 (bounce): go to REL_STABLE, cnt<=0, no output change.
    - Else if cnt==DEBOUNCE_CYCLES-1: go to PRS_STABLE, button_clean<=0, press_pulse<=1.
    - Else cnt<=cnt+1.
  - PRS_STABLE (11): clean=0. If s2==1, go to REL_WAIT with cnt<=0.
  - REL_WAIT (10): mirror of PRESS_WAIT.
    - If s2==0: return to PRS_STABLE.
    - At terminal count with s2==1: go to REL_STABLE, button_clean<=1, release_pulse<=1.
- Pulses are 0 on every edge where the above does not set them, so each is exactly one cycle wide.
- press_pulse and release_pulse are never high together.
- Acceptance rule: s2 must show the new level on DEBOUNCE_CYCLES+1 consecutive edges (the entry edge plus DEBOUNCE_CYCLES counting edges).
  - A raw level lasting DEBOUNCE_CYCLES cycles is rejected.
  - A raw level lasting DEBOUNCE_CYCLES+1 cycles is accepted.
- Latency: if button_raw is first sampled at the new level on edge k and held, button_clean and the pulse change on edge k+2+DEBOUNCE_CYCLES. For DEBOUNCE_CYCLES=1 this is edge k+3.
- Counter:
  - Unsigned, never wraps.
  - Cleared on every WAIT entry and every abort.
  - Holds 0 in the stable states.
- Reset during a WAIT state aborts the count with no pulse.
  - If button_raw is still low after reset deasserts, the press is re-qualified from scratch.
  - A press_pulse then follows normally. This is intended.
- Undefined state encodings go to REL_STABLE with clean=1 on the next edge.

Decomposition:
- Shared constants include:
  - The four state encodings.
  - BTN_PRESSED=1'b0 and BTN_RELEASED=1'b1, also used by the press/release pulse FSM.
  - Default DEBOUNCE_CYCLES for hardware (500000) and simulation (4).
- One sub-module: sync_2ff.
  - Parameterised reset value.
  - Synchronous active-high reset.
  - Reusable for switch inputs.

Test Plan (DEBOUNCE_CYCLES=4, CNT_WIDTH=3):
- Reset: reset=1 for 3 cycles with button_raw=0 → button_clean=1, both pulses 0, cnt=0 throughout reset.
- Clean press: button_raw 1→0 first sampled at edge 10, held → button_clean=0 from edge 16, press_pulse=1 only between edges 16 and 17, release_pulse stays 0.
- Bounce boundary:
  - A 4-cycle low glitch → no change on button_clean, no pulses, FSM back in REL_STABLE.
  - A 5-cycle low pulse → press_pulse once, then a release qualifies 6 cycles after raw returns high.
- Release: from pressed, button_raw 0→1 sampled at edge 40, held → button_clean=1 at edge 46, release_pulse for one cycle.
- Reset mid-count: button_raw held 0, reset asserted while cnt=2 in PRESS_WAIT → next edge clean=1, cnt=0, no pulse. After deassert at edge k, press_pulse at edge k+6.
- Chain: drive button_debouncer.button_clean into the press/release pulse FSM, press with 3 bounces then release with 2 bounces → that FSM's pulse_out asserts exactly once, one cycle, after the release qualifies.
